// File: rtl/i2c_write.sv
// I2C SDA transmitter: drives one bit per SCL low phase (open-drain style),
// pulls the next bit from an external shift register and watches for arbitration loss.
module i2c_write #(
  parameter int HOLD_CYCLES = 2,
  parameter int HOLD_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_wr_en,
  input  logic i_is_byte,
  input  logic i_arb_en,
  input  logic i_data,
  output logic o_wr_ld,
  output logic o_sda,
  output logic o_arb_lost,
  output logic o_wr_finish,
  input  logic i_scl,
  input  logic i_sda
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_DRIVE   = 3'd2;
  localparam logic [2:0] S_HIGH    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_LOST    = 3'd6;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [2:0]        r_state;
  logic [2:0]        r_bit_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_scl_last;
  logic              r_is_byte;
  logic              r_sda;
  logic              r_arb_lost;
  logic              r_wr_finish;

  logic w_fall;
  logic w_rise;
  logic w_last_bit;
  logic w_arb_hit;
  logic w_wr_ld;

  assign w_fall     = r_scl_last & ~i_scl;
  assign w_rise     = ~r_scl_last & i_scl;
  assign w_last_bit = ~r_is_byte | (r_bit_cnt == 3'd7);
  // Only meaningful while SCL is high: we release SDA but someone else holds it low.
  assign w_arb_hit  = i_arb_en & r_sda & ~i_sda & i_scl;

  // Asserted in the fall-detect cycle itself so the external register has shifted
  // before the first hold-count edge samples i_data, even with HOLD_CYCLES=1.
  assign w_wr_ld = ~i_rst & i_wr_en & (r_state == S_HIGH) & w_fall & ~w_last_bit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_hold_cnt  <= '0;
      r_scl_last  <= 1'b1;
      r_is_byte   <= 1'b0;
      r_sda       <= 1'b1;
      r_arb_lost  <= 1'b0;
      r_wr_finish <= 1'b0;
    end else begin
      r_scl_last <= i_scl;
      if (!i_wr_en) begin
        r_state     <= S_IDLE;
        r_sda       <= 1'b1;
        r_bit_cnt   <= 3'd0;
        r_arb_lost  <= 1'b0;
        r_wr_finish <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_is_byte  <= i_is_byte;
            r_hold_cnt <= HOLD_LOAD;
            r_state    <= S_HOLD;
          end
          S_HOLD: begin
            // An early rise here is a timing violation; DRIVE simply waits for the next one.
            if (r_hold_cnt == '0) begin
              r_sda   <= i_data;
              r_state <= S_DRIVE;
            end else begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
          end
          S_DRIVE: begin
            if (w_rise) begin
              if (w_arb_hit) begin
                r_arb_lost <= 1'b1;
                r_sda      <= 1'b1;
                r_state    <= S_LOST;
              end else begin
                r_state <= S_HIGH;
              end
            end
          end
          S_HIGH: begin
            if (w_arb_hit) begin
              r_arb_lost <= 1'b1;
              r_sda      <= 1'b1;
              r_state    <= S_LOST;
            end else if (w_fall) begin
              r_hold_cnt <= HOLD_LOAD;
              if (w_last_bit) begin
                r_state <= S_RELEASE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_state   <= S_HOLD;
              end
            end
          end
          S_RELEASE: begin
            if (r_hold_cnt == '0) begin
              r_sda       <= 1'b1;
              r_wr_finish <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
          end
          S_DONE: begin
            r_sda       <= 1'b1;
            r_wr_finish <= 1'b1;
          end
          S_LOST: begin
            r_sda       <= 1'b1;
            r_arb_lost  <= 1'b1;
            r_wr_finish <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_sda   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_wr_ld     = w_wr_ld;
  assign o_sda       = r_sda;
  assign o_arb_lost  = r_arb_lost;
  assign o_wr_finish = r_wr_finish;

endmodule

// File: tb/tb_i2c_write.sv
// Bench for i2c_write: directed and random transfers against a bit-level transfer model
// (MSB-first bit list, hold delay after each SCL fall, expected load-pulse count).
module tb_i2c_write;

  localparam int H  = 2;   // hold cycles
  localparam int LO = 10;  // SCL low ticks
  localparam int HI = 10;  // SCL high ticks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic is_byte = 1'b1;
  logic arb_en = 1'b0;
  logic data = 1'b1;
  logic scl = 1'b1;
  logic sda_in = 1'b1;
  logic wr_ld;
  logic sda_out;
  logic arb_lost;
  logic wr_finish;

  logic [7:0] sh = 8'hFF;
  logic       force_low = 1'b0;
  logic       ld_seen;
  int         ld_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  i2c_write #(.HOLD_CYCLES(H), .HOLD_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_is_byte(is_byte),
    .i_arb_en(arb_en), .i_data(data), .o_wr_ld(wr_ld), .o_sda(sda_out),
    .o_arb_lost(arb_lost), .o_wr_finish(wr_finish), .i_scl(scl), .i_sda(sda_in)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: load pulse sampled mid-cycle, external register shifts on the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_seen = wr_ld;
      if (ld_seen) ld_cnt++;
      @(posedge clk);
      #1;
      if (ld_seen) begin
        sh   = {sh[6:0], 1'b0};
        data = sh[7];
      end
      sda_in = sda_out & ~force_low;
    end
  endtask

  // lose_hi: high phase index where another master pulls SDA low (-1 none)
  // abort_k: bit index during whose low phase wr_en drops (-1 none)
  task automatic xfer(input logic [7:0] val, input logic mode, input logic arb,
                      input int lose_hi, input int abort_k);
    int   nb;
    logic bitv;
    logic prev;
    nb = mode ? 8 : 1;
    prev = 1'b1;
    ld_cnt = 0;
    force_low = 1'b0;
    wr_en = 1'b0;
    scl = 1'b1;
    tick(2);
    scl = 1'b0;
    tick(1);
    sh = val;
    data = sh[7];
    is_byte = mode;
    arb_en = arb;
    wr_en = 1'b1;
    tick(1);
    for (int k = 0; k < nb; k++) begin
      bitv = val[7-k];
      tick(H - 1);
      chk1("sda_before_hold", sda_out, prev);
      tick(1);
      chk1("sda_after_hold", sda_out, bitv);
      tick(LO - 1 - H);
      if (abort_k == k) begin
        wr_en = 1'b0;
        tick(1);
        chk1("abort_sda", sda_out, 1'b1);
        chk1("abort_finish", wr_finish, 1'b0);
        chk1("abort_lost", arb_lost, 1'b0);
        return;
      end
      scl = 1'b1;
      for (int t = 0; t < HI; t++) begin
        force_low = (lose_hi == k) && (t >= 2);
        sda_in = sda_out & ~force_low;
        tick(1);
        if (force_low && arb && bitv) begin
          chk1("lost_flag", arb_lost, 1'b1);
          chk1("lost_sda", sda_out, 1'b1);
          tick(HI - 1 - t);
          scl = 1'b0;
          tick(LO);
          scl = 1'b1;
          tick(3);
          chk1("lost_sticky", arb_lost, 1'b1);
          chk1("lost_no_finish", wr_finish, 1'b0);
          chk1("lost_sda_rel", sda_out, 1'b1);
          chkn("lost_ld_cnt", ld_cnt, k);
          force_low = 1'b0;
          wr_en = 1'b0;
          tick(1);
          chk1("lost_clear", arb_lost, 1'b0);
          return;
        end
        chk1("sda_high", sda_out, bitv);
        chk1("no_lost", arb_lost, 1'b0);
      end
      force_low = 1'b0;
      scl = 1'b0;
      tick(1);
      chkn("ld_cnt", ld_cnt, (k < nb - 1) ? k + 1 : k);
      prev = bitv;
    end
    tick(H - 1);
    chk1("finish_early", wr_finish, 1'b0);
    chk1("last_bit_hold", sda_out, prev);
    tick(1);
    chk1("finish", wr_finish, 1'b1);
    chk1("release_sda", sda_out, 1'b1);
    chkn("ld_total", ld_cnt, nb - 1);
    scl = 1'b1;
    tick(3);
    scl = 1'b0;
    tick(3);
    chk1("done_ignores_scl", wr_finish, 1'b1);
    chk1("done_sda", sda_out, 1'b1);
    chkn("done_ld", ld_cnt, nb - 1);
    wr_en = 1'b0;
    tick(1);
    chk1("finish_clear", wr_finish, 1'b0);
  endtask

  initial begin
    logic [7:0] rv;
    logic       rm;
    logic       ra;
    tick(2);
    chk1("rst_sda", sda_out, 1'b1);
    chk1("rst_ld", wr_ld, 1'b0);
    chk1("rst_lost", arb_lost, 1'b0);
    chk1("rst_finish", wr_finish, 1'b0);
    rst = 1'b0;
    tick(2);

    xfer(8'hA5, 1'b1, 1'b0, -1, -1);
    xfer(8'h00, 1'b0, 1'b1, -1, -1);   // ACK bit
    xfer(8'h80, 1'b0, 1'b1, -1, -1);   // NACK bit
    xfer(8'hFF, 1'b1, 1'b1, 2, -1);
    xfer(8'hFF, 1'b1, 1'b0, 2, -1);
    xfer(8'hA5, 1'b1, 1'b1, -1, 4);
    xfer(8'hA5, 1'b1, 1'b1, -1, -1);

    for (int i = 0; i < 6; i++) begin
      rv = 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      xfer(rv, rm, ra, -1, -1);
    end
    rv = 8'($urandom);
    xfer(rv, 1'b1, 1'b0, -1, int'($urandom_range(0, 6)));
    xfer(rv, 1'b1, 1'b0, -1, -1);

    // Reset in the middle of a byte while SDA is driven low
    scl = 1'b0;
    tick(2);
    sh = 8'h00;
    data = 1'b0;
    is_byte = 1'b1;
    ld_cnt = 0;
    wr_en = 1'b1;
    tick(3);
    chk1("pre_rst_sda", sda_out, 1'b0);
    rst = 1'b1;
    tick(1);
    chk1("mid_rst_sda", sda_out, 1'b1);
    chk1("mid_rst_ld", wr_ld, 1'b0);
    chk1("mid_rst_lost", arb_lost, 1'b0);
    chk1("mid_rst_finish", wr_finish, 1'b0);
    for (int j = 0; j < 3; j++) begin
      scl = 1'b1;
      tick(4);
      scl = 1'b0;
      tick(4);
    end
    chk1("rst_hold_sda", sda_out, 1'b1);
    chkn("rst_hold_ld", ld_cnt, 0);
    chk1("rst_hold_finish", wr_finish, 1'b0);
    rst = 1'b0;
    wr_en = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
